// File: rtl/mac_requant.sv
// Window decimator + requantizer: keeps every window_p-th accumulator sample, shifts/saturates it to
// int_out_p.frac_out_p. Define MAC_REQUANT_ROUND_EN for round-half-up instead of truncation.
module mac_requant #(
  parameter int int_in_p   = 10,
  parameter int frac_in_p  = 22,
  parameter int int_out_p  = 1,
  parameter int frac_out_p = 11,
  parameter int window_p   = 8
) (
  input  logic                                     clk_i,
  input  logic                                     reset_ni,
  input  logic signed [int_in_p+frac_in_p-1:0]     data_i,
  input  logic                                     valid_i,
  output logic                                     ready_o,
  output logic signed [int_out_p+frac_out_p-1:0]   data_o,
  output logic                                     sat_o,
  output logic                                     valid_o,
  input  logic                                     ready_i,
  input  logic                                     clear_i
);
  localparam int IN_W  = int_in_p + frac_in_p;
  localparam int OUT_W = int_out_p + frac_out_p;
  localparam int SH    = frac_in_p - frac_out_p;
  localparam int CW    = (window_p > 1) ? $clog2(window_p) : 1;

  if (frac_in_p <= frac_out_p || int_in_p < int_out_p || window_p < 1) begin : g_bad_cfg
    $error("mac_requant: illegal parameter combination");
  end

  localparam logic [CW-1:0]        LAST = CW'(window_p - 1);
  localparam logic [CW-1:0]        CLR1 = CW'((window_p > 1) ? 1 : 0);
  localparam logic signed [IN_W:0] MAXV = (IN_W+1)'((2 ** (OUT_W - 1)) - 1);
  localparam logic signed [IN_W:0] MINV = -MAXV - 1;
`ifdef MAC_REQUANT_ROUND_EN
  localparam logic signed [IN_W:0] RND  = (IN_W+1)'(1) <<< (SH - 1);
`else
  localparam logic signed [IN_W:0] RND  = '0;
`endif

  logic [CW-1:0]        cnt_r;
  logic                 last, acc, term;
  logic signed [IN_W:0] ext, rnd, shf;
  logic signed [OUT_W-1:0] q;
  logic                 q_sat;

  assign last    = (cnt_r == LAST);
  assign ready_o = !last || !valid_o || ready_i;
  assign acc     = valid_i && ready_o;
  // A clearing cycle always restarts the window, so its sample can never close one.
  assign term    = acc && last && !clear_i;

  // One guard bit keeps the rounding add from wrapping at the positive extreme.
  assign ext = {data_i[IN_W-1], data_i};
  assign rnd = ext + RND;
  assign shf = rnd >>> SH;

  always_comb begin
    q     = shf[OUT_W-1:0];
    q_sat = 1'b0;
    if (shf > MAXV) begin
      q     = MAXV[OUT_W-1:0];
      q_sat = 1'b1;
    end else if (shf < MINV) begin
      q     = MINV[OUT_W-1:0];
      q_sat = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      cnt_r <= '0;
    end else if (clear_i) begin
      cnt_r <= acc ? CLR1 : '0;
    end else if (acc) begin
      cnt_r <= last ? '0 : cnt_r + CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      valid_o <= 1'b0;
      data_o  <= '0;
      sat_o   <= 1'b0;
    end else if (term) begin
      valid_o <= 1'b1;
      data_o  <= q;
      sat_o   <= q_sat;
    end else if (valid_o && ready_i) begin
      valid_o <= 1'b0;
    end
  end
endmodule

// File: tb/tb_mac_requant.sv
// Directed bench for mac_requant at window_p=4; expectations follow MAC_REQUANT_ROUND_EN.
module tb_mac_requant;
  logic        clk_i = 1'b0;
  logic        reset_ni = 1'b0;
  logic [31:0] data_i = '0;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic [11:0] data_o;
  logic        sat_o;
  logic        valid_o;
  logic        ready_i = 1'b1;
  logic        clear_i = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  mac_requant #(.window_p(4)) dut (
    .clk_i(clk_i), .reset_ni(reset_ni), .data_i(data_i), .valid_i(valid_i),
    .ready_o(ready_o), .data_o(data_o), .sat_o(sat_o), .valid_o(valid_o),
    .ready_i(ready_i), .clear_i(clear_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push(input logic [31:0] d);
    valid_i = 1'b1;
    data_i  = d;
    tick();
    valid_i = 1'b0;
  endtask

  // Three discarded fillers then the terminal sample; checks silence before the terminal.
  task automatic window(input string tag, input logic [31:0] d);
    for (int i = 0; i < 3; i++) begin
      push(32'h7FFF_0000 - 32'(i));
      chk({tag, "_quiet"}, 32'(valid_o), 32'd0);
    end
    push(d);
  endtask

  logic [11:0] rpos, rneg;

  initial begin
`ifdef MAC_REQUANT_ROUND_EN
    rpos = 12'h001; rneg = 12'h000;
`else
    rpos = 12'h000; rneg = 12'hFFF;
`endif
    tick(); tick();
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_data",  32'(data_o),  32'd0);
    chk("rst_sat",   32'(sat_o),   32'd0);
    reset_ni = 1'b1;
    tick();
    chk("rst_ready", 32'(ready_o), 32'd1);

    window("half", 32'h0020_0000);
    chk("half_valid", 32'(valid_o), 32'd1);
    chk("half_data",  32'(data_o),  32'h400);
    chk("half_sat",   32'(sat_o),   32'd0);
    tick();
    chk("half_drop", 32'(valid_o), 32'd0);

    window("p3", 32'h00C0_0000);
    chk("p3_data", 32'(data_o), 32'h7FF);
    chk("p3_sat",  32'(sat_o),  32'd1);
    window("m5", 32'hFEC0_0000);
    chk("m5_data", 32'(data_o), 32'h800);
    chk("m5_sat",  32'(sat_o),  32'd1);
    window("rp", 32'h0000_0400);
    chk("rp_data", 32'(data_o), 32'(rpos));
    chk("rp_sat",  32'(sat_o),  32'd0);
    window("rn", 32'hFFFF_FC00);
    chk("rn_data", 32'(data_o), 32'(rneg));
    tick();

    // Backpressure: pending result held while the next window fills.
    ready_i = 1'b0;
    window("bp1", 32'h0020_0000);
    chk("bp1_valid", 32'(valid_o), 32'd1);
    for (int i = 0; i < 3; i++) begin
      chk("bp_ready_nt", 32'(ready_o), 32'd1);
      push(32'h0000_1234);
      chk("bp_hold", 32'(data_o), 32'h400);
    end
    valid_i = 1'b1;
    data_i  = 32'h0010_0000;
    #1;
    chk("bp_ready_t", 32'(ready_o), 32'd0);
    tick(); tick();
    chk("bp_stall_v", 32'(valid_o), 32'd1);
    chk("bp_stall_d", 32'(data_o), 32'h400);
    ready_i = 1'b1;
    #1;
    chk("bp_ready_rel", 32'(ready_o), 32'd1);
    tick();
    valid_i = 1'b0;
    chk("bp2_valid", 32'(valid_o), 32'd1);
    chk("bp2_data",  32'(data_o),  32'h200);
    tick();
    chk("bp2_drop", 32'(valid_o), 32'd0);

    // Clear after two accepts restarts the window.
    push(32'h1); push(32'h2);
    clear_i = 1'b1; tick(); clear_i = 1'b0;
    window("clr", 32'h0020_0000);
    chk("clr_valid", 32'(valid_o), 32'd1);
    tick();

    // Clear coinciding with a would-be terminal accept counts as index 0.
    push(32'h1); push(32'h2); push(32'h3);
    clear_i = 1'b1; push(32'h0020_0000); clear_i = 1'b0;
    chk("clracc_noterm", 32'(valid_o), 32'd0);
    push(32'h4); push(32'h5);
    chk("clracc_quiet", 32'(valid_o), 32'd0);
    push(32'h0010_0000);
    chk("clracc_valid", 32'(valid_o), 32'd1);
    chk("clracc_data",  32'(data_o),  32'h200);

    // Clear must leave a pending output untouched.
    ready_i = 1'b0;
    tick();
    clear_i = 1'b1; tick(); clear_i = 1'b0;
    chk("clrpend_valid", 32'(valid_o), 32'd1);
    chk("clrpend_data",  32'(data_o),  32'h200);

    // Reset with a pending result and a partial window.
    push(32'h1); push(32'h2);
    reset_ni = 1'b0; tick();
    chk("rst2_valid", 32'(valid_o), 32'd0);
    chk("rst2_data",  32'(data_o),  32'd0);
    reset_ni = 1'b1; ready_i = 1'b1;
    tick();
    chk("rst2_ready", 32'(ready_o), 32'd1);
    window("rst2", 32'h00C0_0000);
    chk("rst2_win", 32'(valid_o), 32'd1);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mac_requant.md
MAC_REQUANT -- requirements
Module: mac_requant

Interface
REQ-001 The block SHALL have parameter int_in_p, default 10, meaning integer bits of the input fixed-point sample, sign bit included.
REQ-002 The block SHALL have parameter frac_in_p, default 22, meaning fractional bits of the input sample.
REQ-003 The block SHALL have parameter int_out_p, default 1, meaning integer bits of the output sample, sign bit included.
REQ-004 The block SHALL have parameter frac_out_p, default 11, meaning fractional bits of the output sample.
REQ-005 The block SHALL have parameter window_p, default 8, meaning accepted input samples per emitted result.
REQ-006 Port clk_i: input, 1 bit, the single clock; all state SHALL update on its rising edge.
REQ-007 Port reset_ni: input, 1 bit; reset SHALL be synchronous and active-low.
REQ-008 Port data_i: input, signed, int_in_p+frac_in_p bits, running accumulator value from the upstream MAC.
REQ-009 Port valid_i: input, 1 bit, data_i valid.
REQ-010 Port ready_o: output, 1 bit, the block can accept data_i.
REQ-011 Port data_o: output, signed, int_out_p+frac_out_p bits, requantized window result.
REQ-012 Port sat_o: output, 1 bit, data_o was clipped; qualified by valid_o.
REQ-013 Port valid_o: output, 1 bit, data_o/sat_o valid.
REQ-014 Port ready_i: input, 1 bit, downstream accepts data_o.
REQ-015 Port clear_i: input, 1 bit, synchronous restart of the window count.

Function
REQ-016 An input sample SHALL be accepted only in a cycle with valid_i=1 and ready_o=1; an output SHALL be consumed only with valid_o=1 and ready_i=1.
REQ-017 Counter cnt_r (0..window_p-1) SHALL increment on each accept and wrap to 0 on an accept while cnt_r=window_p-1 (terminal accept).
REQ-018 Non-terminal accepted samples SHALL be discarded; only the terminal sample is requantized and registered.
REQ-019 ready_o SHALL equal (cnt_r != window_p-1) OR (valid_o=0) OR (ready_i=1); non-terminal samples are never stalled.
REQ-020 Latency SHALL be one cycle: valid_o rises on the edge following a terminal accept; data_o/sat_o hold stable while valid_o=1 and ready_i=0.
REQ-021 On a consume with no terminal accept in the same cycle, valid_o SHALL fall; a simultaneous consume and terminal accept SHALL load the new result with valid_o remaining 1.
REQ-022 Requantization SHALL arithmetic-shift data_i right by frac_in_p-frac_out_p bits, computed in a width at least one bit wider than data_i so that no intermediate overflow occurs.
REQ-023 The result SHALL saturate to [-2^(int_out_p-1), 2^(int_out_p-1) - 2^-frac_out_p]; sat_o=1 exactly when clipping occurred.
REQ-024 clear_i=1 SHALL set cnt_r to 0 at the next edge; if a sample is accepted in the same cycle it SHALL count as index 0 (next cnt_r=1), and it SHALL never be treated as terminal.
REQ-025 clear_i SHALL NOT drop or modify a pending output (valid_o, data_o, sat_o unchanged).
REQ-026 Elaboration SHALL fail if frac_in_p <= frac_out_p, int_in_p < int_out_p, or window_p < 1; for window_p=1 every accept is terminal.

Reset
REQ-027 With reset_ni=0 at a rising edge: cnt_r=0, valid_o=0, data_o=0, sat_o=0.
REQ-028 Reset asserted mid-window or with a pending output SHALL discard the partial count and the pending result; ready_o SHALL be 1 in the first cycle after reset release.

Configuration
REQ-029 When macro MAC_REQUANT_ROUND_EN is defined, the block SHALL add 2^(frac_in_p-frac_out_p-1) input LSBs before shifting (round half up), with saturation applied after rounding.
REQ-030 When MAC_REQUANT_ROUND_EN is undefined, the block SHALL truncate (floor); all other behaviour is identical.

Verification (defaults, window_p=4, ready_i=1 unless stated)
REQ-031 Send 4 samples, the last one 0x00200000 (0.5) -> one output 0x400, sat_o=0, one cycle after the 4th accept; no output for samples 1-3.
REQ-032 Terminal sample 0x00C00000 (3.0) -> 0x7FF, sat_o=1; terminal sample 0xFEC00000 (-5.0) -> 0x800, sat_o=1.
REQ-033 Terminal 0x00000400 -> 0x001 with ROUND_EN, 0x000 without; terminal 0xFFFFFC00 -> 0x000 with ROUND_EN, 0xFFF without.
REQ-034 ready_i=0 with a result pending, then 4 more samples -> first 3 accepted with ready_o=1, ready_o=0 on the 4th until ready_i=1; the first result is held unchanged, then replaced by the second.
REQ-035 Pulse clear_i after 2 accepts, then send 4 samples -> output only after the 4th post-clear accept; reset_ni=0 with valid_o=1 -> valid_o=0, data_o=0 on the next edge.
